// File: rtl/alu_pkg.sv
// Shared opcodes and FSM states for the sequential ALU.
package alu_pkg;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SLTU  = 4'b0011;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_MULTU = 4'b1000;
   localparam logic [3:0] OP_DIVU  = 4'b1001;
   localparam logic [3:0] OP_NOR   = 4'b1100;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } state_t;

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Divide mode exists only when ALU_SEQ_DIV_EN is defined.
module alu_seq_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] r_hi, r_lo, r_b;
   logic [CNT_W-1:0] r_cnt;
   logic             r_act, r_mode;

   logic [WIDTH-1:0] w_hi_s, w_lo_s, w_b;
   logic [WIDTH-1:0] w_hi_n, w_lo_n;
   logic             w_mode;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_rem;
   logic             w_ge;

   // The first step is applied on the start edge to the fresh operands.
   always_comb begin
      w_hi_s = start ? '0 : r_hi;
      w_lo_s = start ? a : r_lo;
      w_b    = start ? b : r_b;
      w_mode = start ? mode : r_mode;
      w_sum  = {1'b0, w_hi_s} + (w_lo_s[0] ? {1'b0, w_b} : '0);
      w_rem  = {w_hi_s, w_lo_s[WIDTH-1]};
      w_ge   = (w_rem >= {1'b0, w_b});
      w_hi_n = w_sum[WIDTH:1];
      w_lo_n = {w_sum[0], w_lo_s[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
      if (w_mode) begin
         w_hi_n = w_ge ? (w_rem[WIDTH-1:0] - w_b) : w_rem[WIDTH-1:0];
         w_lo_n = {w_lo_s[WIDTH-2:0], w_ge};
      end
`else
      if (w_mode) begin
         w_hi_n = w_hi_s;
         w_lo_n = w_lo_s;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi   <= '0;
         r_lo   <= '0;
         r_b    <= '0;
         r_cnt  <= '0;
         r_act  <= 1'b0;
         r_mode <= 1'b0;
      end else if (start) begin
         r_hi   <= w_hi_n;
         r_lo   <= w_lo_n;
         r_b    <= b;
         r_mode <= mode;
         r_cnt  <= CNT_W'(WIDTH - 1);
         r_act  <= 1'b1;
      end else if (r_act) begin
         if (r_cnt == '0) begin
            r_act <= 1'b0;
         end else begin
            r_hi  <= w_hi_n;
            r_lo  <= w_lo_n;
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign hi   = r_hi;
   assign lo   = r_lo;
   assign done = r_act && (r_cnt == '0);

endmodule

// File: rtl/alu_seq.sv
// EX-stage ALU: registered single-cycle ops plus iterative multu/divu.
// Define ALU_SEQ_DIV_EN to include the divider.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       operation,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             err,
   output logic             busy
);

   state_t           r_state, w_state_n;
   logic [WIDTH-1:0] r_res, r_res_hi;
   logic             r_zero, r_err;

   logic             w_start, w_mode, w_load, w_err, w_done;
   logic [WIDTH-1:0] w_res, w_res_hi, w_hi, w_lo;

   alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
      .clk   (clk),
      .rst_n (rst_n),
      .start (w_start),
      .mode  (w_mode),
      .a     (a),
      .b     (b),
      .hi    (w_hi),
      .lo    (w_lo),
      .done  (w_done)
   );

   always_comb begin
      w_state_n = r_state;
      w_start   = 1'b0;
      w_mode    = 1'b0;
      w_load    = 1'b0;
      w_res     = '0;
      w_res_hi  = '0;
      w_err     = 1'b0;
      unique case (r_state)
         S_IDLE: if (in_valid) begin
            w_load    = 1'b1;
            w_state_n = S_DONE;
            unique case (operation)
               OP_ADD:  w_res = a + b;
               OP_SUB:  w_res = a - b;
               OP_AND:  w_res = a & b;
               OP_OR:   w_res = a | b;
               OP_NOR:  w_res = ~(a | b);
               OP_SLT:  w_res = WIDTH'($signed(a) < $signed(b));
               OP_SLTU: w_res = WIDTH'(a < b);
               OP_MULTU: begin
                  w_load    = 1'b0;
                  w_start   = 1'b1;
                  w_state_n = S_MUL;
               end
`ifdef ALU_SEQ_DIV_EN
               OP_DIVU: if (b == '0) begin
                  w_res    = '1;
                  w_res_hi = a;
                  w_err    = 1'b1;
               end else begin
                  w_load    = 1'b0;
                  w_start   = 1'b1;
                  w_mode    = 1'b1;
                  w_state_n = S_DIV;
               end
`endif
               default: w_err = 1'b1;
            endcase
         end
         S_MUL, S_DIV: if (w_done) begin
            w_load    = 1'b1;
            w_res     = w_lo;
            w_res_hi  = w_hi;
            w_state_n = S_DONE;
         end
         S_DONE: if (out_ready) w_state_n = S_IDLE;
         default: w_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_res    <= '0;
         r_res_hi <= '0;
         r_zero   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_state_n;
         if (w_load) begin
            r_res    <= w_res;
            r_res_hi <= w_res_hi;
            r_zero   <= (w_res == '0);
            r_err    <= w_err;
         end
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state == S_MUL) || (r_state == S_DIV);
   assign result    = r_res;
   assign result_hi = r_res_hi;
   assign zero      = r_zero;
   assign err       = r_err;

endmodule
